// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin front end for a shared iterative 16x16 signed
// shift-add multiplier. One operand pair in flight at a time; the product is
// returned with the id of the requester that issued it.
module mult_share_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_p,
  output logic                 res_id,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [2*WIDTH-1:0]   r_p;
  logic [CW-1:0]        r_i;
  logic                 r_id;
  logic                 r_last;

  logic                 w_grant;
  logic                 w_acc0;
  logic                 w_acc1;
  logic                 w_accept;
  logic                 w_last_iter;
  logic [WIDTH-1:0]     w_h;
  logic [WIDTH-1:0]     w_l;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_p_nxt;

  assign w_acc0      = req0_valid && req0_ready;
  assign w_acc1      = req1_valid && req1_ready;
  assign w_accept    = w_acc0 || w_acc1;
  assign w_last_iter = (r_i == LAST_ITER);

  // Round-robin grant: lone requester wins, ties go to the one not served last
  always_comb begin
    if (req0_valid && !req1_valid)      w_grant = 1'b0;
    else if (req1_valid && !req0_valid) w_grant = 1'b1;
    else                                w_grant = ~r_last;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; the iteration counter alone ends RUN
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_nxt = RUN;
      RUN:     if (w_last_iter) w_state_nxt = DONE;
      DONE:    if (res_ready)   w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Handshake and result outputs decoded from state
  always_comb begin
    req0_ready = (r_state == IDLE) && !rst && !w_grant;
    req1_ready = (r_state == IDLE) && !rst &&  w_grant;
    busy       = (r_state != IDLE);
    res_valid  = (r_state == DONE);
    res_p      = (r_state == DONE) ? r_p  : '0;
    res_id     = (r_state == DONE) ? r_id : 1'b0;
  end

  // One shift-add step; W+1-bit sum keeps the carry of the final subtract
  always_comb begin
    w_h = r_p[2*WIDTH-1:WIDTH];
    w_l = r_p[WIDTH-1:0];
    if (w_l[0]) begin
      if (w_last_iter) w_sum = {w_h[WIDTH-1], w_h} - {r_a[WIDTH-1], r_a};
      else             w_sum = {w_h[WIDTH-1], w_h} + {r_a[WIDTH-1], r_a};
    end else begin
      w_sum = {w_h[WIDTH-1], w_h};
    end
    w_p_nxt = {w_sum, w_l[WIDTH-1:1]};
  end

  // Operand capture on accept, iteration in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_p    <= '0;
      r_i    <= '0;
      r_id   <= 1'b0;
      r_last <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a    <= w_acc1 ? req1_a : req0_a;
            r_p    <= {{WIDTH{1'b0}}, (w_acc1 ? req1_b : req0_b)};
            r_id   <= w_acc1;
            r_last <= w_acc1;
            r_i    <= '0;
          end
        end
        RUN: begin
          r_p <= w_p_nxt;
          r_i <= r_i + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: scoreboard bench for mult_share_ctrl. Expected products
// are queued at accept time and compared when the result handshake fires.
module tb_mult_share_ctrl;

  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [W-1:0]     req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             res_valid, res_ready = 1'b0;
  logic [2*W-1:0]   res_p;
  logic             res_id, busy;

  mult_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic signed [W-1:0] a; logic signed [W-1:0] b; } op_t;
  typedef struct { logic id; logic [2*W-1:0] p; } exp_t;

  op_t   q0[$], q1[$];
  exp_t  sb[$];
  int    acc_log[$];

  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, acc_cyc = 0, xfer_cyc = 0;
  int          n_acc = 0, n_res = 0, n_abort = 0;
  int          rr_mode = 0;     // 0: ready high, 1: ready low, 2: random
  logic        rst_req = 1'b1;
  logic        inflight = 1'b0, last_srv = 1'b1, lat_pending = 1'b0;
  logic        hold_valid = 1'b0, hold_id = 1'b0, gap_chk = 1'b0;
  logic [2*W-1:0] hold_p = '0, last_p = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push(input int id, input int a, input int b);
    op_t o;
    o.a = W'(a);
    o.b = W'(b);
    if (id == 0) q0.push_back(o);
    else         q1.push_back(o);
  endtask

  task automatic note_accept(input logic id, input op_t o);
    exp_t e;
    logic signed [2*W-1:0] pr;
    pr   = o.a * o.b;
    e.id = id;
    e.p  = pr;
    sb.push_back(e);
    acc_log.push_back(int'(id));
    last_srv    = id;
    inflight    = 1'b1;
    lat_pending = 1'b1;
    acc_cyc     = cyc;
    n_acc++;
    if (gap_chk) begin
      check("bp_accept_gap", 64'(cyc - xfer_cyc), 64'd1);
      gap_chk = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, observe 1 time unit later
  task automatic cycle();
    logic g;
    exp_t e;
    op_t  o;
    @(negedge clk);
    rst = rst_req;
    req0_valid = (q0.size() > 0);
    if (req0_valid) begin req0_a = q0[0].a; req0_b = q0[0].b; end
    else begin req0_a = W'($urandom); req0_b = W'($urandom); end
    req1_valid = (q1.size() > 0);
    if (req1_valid) begin req1_a = q1[0].a; req1_b = q1[0].b; end
    else begin req1_a = W'($urandom); req1_b = W'($urandom); end
    case (rr_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'b0;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    cyc++;
    if (rst) begin
      check("rdy_in_rst", {req0_ready, req1_ready}, 2'b00);
      n_abort    += sb.size();
      sb.delete();
      inflight    = 1'b0;
      last_srv    = 1'b1;
      lat_pending = 1'b0;
      hold_valid  = 1'b0;
      return;
    end
    check("busy", busy, inflight);
    if (inflight) begin
      check("rdy_busy", {req0_ready, req1_ready}, 2'b00);
    end else if (req0_valid || req1_valid) begin
      g = (req0_valid && req1_valid) ? ~last_srv : req1_valid;
      check("grant", {req0_ready, req1_ready}, {~g, g});
    end
    if (res_valid && hold_valid) begin
      check("hold_p", res_p, hold_p);
      check("hold_id", res_id, hold_id);
    end
    hold_valid = res_valid && !res_ready;
    hold_p     = res_p;
    hold_id    = res_id;
    if (res_valid && lat_pending) begin
      check("latency", 64'(cyc - acc_cyc), 64'(W + 1));
      lat_pending = 1'b0;
    end
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("spurious_result", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("res_p", res_p, e.p);
        check("res_id", res_id, e.id);
      end
      last_p   = res_p;
      n_res++;
      inflight = 1'b0;
      xfer_cyc = cyc;
    end
    if (req0_valid && req0_ready) begin o = q0.pop_front(); note_accept(1'b0, o); end
    if (req1_valid && req1_ready) begin o = q1.pop_front(); note_accept(1'b1, o); end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || inflight) && n < limit) begin
      cycle();
      n++;
    end
    check("drain_done", (q0.size() > 0 || q1.size() > 0 || inflight), 1'b0);
  endtask

  initial begin
    int n;
    int a, b;

    // Reset values
    rst_req = 1'b1;
    repeat (3) cycle();
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_p", res_p, '0);
    check("rst_res_id", res_id, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_req = 1'b0;
    cycle();

    // Single request
    push(0, 3, -5);
    drain(100);
    check("single_p", last_p, 32'hFFFF_FFF1);

    // Corner products through requester 1
    push(1, -32768, -32768); drain(100); check("corner_minmin", last_p, 32'h4000_0000);
    push(1, -32768, 1);      drain(100); check("corner_min1",   last_p, 32'hFFFF_8000);
    push(1, 32767, 32767);   drain(100); check("corner_maxmax", last_p, 32'h3FFF_0001);
    push(1, 0, -1);          drain(100); check("corner_zero",   last_p, 32'h0000_0000);

    // Contention: both valid continuously, last served was 1
    acc_log.delete();
    push(0, 2, 7);  push(0, 2, 7);
    push(1, -4, 9); push(1, -4, 9);
    drain(200);
    check("tie_count", acc_log.size(), 4);
    for (int i = 0; i < acc_log.size(); i++)
      check("tie_order", acc_log[i], i % 2);

    // Backpressure: hold the product 10 cycles with req1 pending
    rr_mode = 1;
    push(0, 11, 12);
    n = 0;
    while (!res_valid && n < 50) begin cycle(); n++; end
    check("bp_valid_seen", res_valid, 1'b1);
    push(1, 13, -14);
    repeat (10) cycle();
    rr_mode = 0;
    gap_chk = 1'b1;
    drain(100);
    check("bp_accept_seen", gap_chk, 1'b0);

    // Reset in the middle of RUN
    push(0, 1234, -77);
    n = 0;
    while (!inflight && n < 20) begin cycle(); n++; end
    repeat (8) cycle();
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    check("abort_no_valid", res_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    push(0, 5, 6);
    drain(100);
    check("post_rst_p", last_p, 32'd30);

    // Random pairs across both requesters with random res_ready
    rr_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 65535)) - 32768;
      b = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 7) == 0) a = -32768;
      if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 1) ? -32768 : 32767;
      push(int'($urandom_range(0, 1)), a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 30)) cycle();
    end
    drain(80000);
    rr_mode = 0;
    check("no_lost_dup", n_res, n_acc - n_abort);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
